// File: rtl/systolic_gemm_engine_pkg.sv
// Shared definitions for the systolic GEMM engine.
//   run_state_e : run-control FSM states (IDLE -> LOAD -> FLUSH -> DRAIN)
//   idx_w()     : index width for an n-entry range, never narrower than 1 bit
package systolic_gemm_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } run_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_gemm_engine_pe.sv
// gemm_pe: one output-stationary processing element.
// It registers the A operand (passed right) and the B operand (passed down),
// each with its own valid bit. It accumulates A*B whenever both registered
// operands are valid. 'clear' zeroes the accumulator and takes priority.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   clear                  synchronous accumulator clear
//   a_in/a_vld_in          A operand from the left neighbour or the skew line
//   b_in/b_vld_in          B operand from the upper neighbour or the skew line
//   a_out/a_vld_out        registered A towards the right neighbour
//   b_out/b_vld_out        registered B towards the lower neighbour
//   acc_out                running sum, ACC_W bits, wraps modulo 2^ACC_W
module gemm_pe
    import systolic_gemm_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    output logic [ACC_W-1:0]  acc_out
);

    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam int PROD_W    = 2 * DATA_W;

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W-1:0]  prod_ext;

    // Both operands are extended to the full product width before the
    // multiply. The low PROD_W bits of the product are then exact for
    // both signed and unsigned operands.
    always_comb begin
        a_d      = a_in;
        a_vld_d  = a_vld_in;
        b_d      = b_in;
        b_vld_d  = b_vld_in;
        a_ext    = {{DATA_W{IS_SIGNED & a_q[DATA_W-1]}}, a_q};
        b_ext    = {{DATA_W{IS_SIGNED & b_q[DATA_W-1]}}, b_q};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-PROD_W){IS_SIGNED & prod[PROD_W-1]}}, prod};
        acc_d    = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (a_vld_q && b_vld_q) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            a_vld_q <= 1'b0;
            b_q     <= '0;
            b_vld_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            a_q     <= a_d;
            a_vld_q <= a_vld_d;
            b_q     <= b_d;
            b_vld_q <= b_vld_d;
            acc_q   <= acc_d;
        end
    end

    assign a_out     = a_q;
    assign a_vld_out = a_vld_q;
    assign b_out     = b_q;
    assign b_vld_out = b_vld_q;
    assign acc_out   = acc_q;

endmodule

// File: rtl/systolic_gemm_engine.sv
// systolic_gemm_engine: output-stationary MxN MAC array computing
// C = A(MxK) * B(KxN) for a runtime K. Each beat carries one A column (M
// lanes) and one B row (N lanes). The results drain as a row-major stream.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start, k_len           launch a run (accepted in IDLE only); k_len = beats
//   busy                   high from accepted start until last result accepted
//   a_vec, b_vec, in_valid beat data with a joint valid; in_ready accepts it
//   res_data/row/col       C[r][c] with its coordinates
//   res_valid/res_ready    result handshake; res_last marks C[M-1][N-1]
module systolic_gemm_engine
    import systolic_gemm_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int K_W    = 16,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    output logic                  busy,
    output logic                  in_ready,
    input  logic [M*DATA_W-1:0]   a_vec,
    input  logic [N*DATA_W-1:0]   b_vec,
    input  logic                  in_valid,
    output logic [ACC_W-1:0]      res_data,
    output logic [idx_w(M)-1:0]   res_row,
    output logic [idx_w(N)-1:0]   res_col,
    output logic                  res_valid,
    output logic                  res_last,
    input  logic                  res_ready
);

    localparam int ROW_W   = idx_w(M);
    localparam int COL_W   = idx_w(N);
    localparam int FLUSH_W = idx_w(M + N);

    run_state_e        state_q, state_d;
    logic [K_W-1:0]    k_len_q, k_len_d;
    logic [K_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;

    logic start_acc, beat_acc, res_acc, last_pos;

    logic [DATA_W-1:0] a_skew [M];
    logic              a_skew_vld [M];
    logic [DATA_W-1:0] b_skew [N];
    logic              b_skew_vld [N];
    logic [DATA_W-1:0] a_pass [M][N];
    logic              a_pass_vld [M][N];
    logic [DATA_W-1:0] b_pass [M][N];
    logic              b_pass_vld [M][N];
    logic [ACC_W-1:0]  acc [M][N];

    // Handshakes and outputs come from registered state only. The result
    // fields are therefore stable while a result waits for res_ready.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        in_ready  = (state_q == ST_LOAD);
        res_valid = (state_q == ST_DRAIN);
        start_acc = start && (state_q == ST_IDLE);
        beat_acc  = in_valid && in_ready;
        res_acc   = res_valid && res_ready;
        last_pos  = (row_q == ROW_W'(M - 1)) && (col_q == COL_W'(N - 1));
        res_last  = res_valid && last_pos;
        res_row   = res_valid ? row_q : '0;
        res_col   = res_valid ? col_q : '0;
        res_data  = res_valid ? acc[row_q][col_q] : '0;
    end

    // Run FSM and counters. FLUSH lasts M+N-1 cycles. That is long enough
    // for the last beat to reach PE(M-1,N-1) and be accumulated there.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    k_len_d     = k_len;
                    beat_cnt_d  = '0;
                    flush_cnt_d = '0;
                    row_d       = '0;
                    col_d       = '0;
                    state_d     = (k_len == '0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_acc) begin
                    if (beat_cnt_q == k_len_q - K_W'(1)) begin
                        beat_cnt_d = '0;
                        state_d    = ST_FLUSH;
                    end else begin
                        beat_cnt_d = beat_cnt_q + K_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(M + N - 2)) begin
                    flush_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            ST_DRAIN: begin
                if (res_acc) begin
                    if (last_pos) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ST_IDLE;
                    end else if (col_q == COL_W'(N - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

    // A skew: lane i is delayed i cycles before it enters PE(i,0).
    // Each lane carries its own valid bit, so bubbles move through as invalid.
    for (genvar i = 0; i < M; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_skew[i]     = a_vec[i*DATA_W +: DATA_W];
            assign a_skew_vld[i] = beat_acc;
        end else begin : g_delay
            logic [DATA_W-1:0] dly_q [i];
            logic [DATA_W-1:0] dly_d [i];
            logic [i-1:0]      vld_q, vld_d;
            always_comb begin
                dly_d[0] = a_vec[i*DATA_W +: DATA_W];
                vld_d[0] = beat_acc;
                for (int s = 1; s < i; s++) begin
                    dly_d[s] = dly_q[s-1];
                    vld_d[s] = vld_q[s-1];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) dly_q[s] <= '0;
                    vld_q <= '0;
                end else begin
                    dly_q <= dly_d;
                    vld_q <= vld_d;
                end
            end
            assign a_skew[i]     = dly_q[i-1];
            assign a_skew_vld[i] = vld_q[i-1];
        end
    end

    // B skew: lane j is delayed j cycles before it enters PE(0,j).
    for (genvar j = 0; j < N; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_skew[j]     = b_vec[j*DATA_W +: DATA_W];
            assign b_skew_vld[j] = beat_acc;
        end else begin : g_delay
            logic [DATA_W-1:0] dly_q [j];
            logic [DATA_W-1:0] dly_d [j];
            logic [j-1:0]      vld_q, vld_d;
            always_comb begin
                dly_d[0] = b_vec[j*DATA_W +: DATA_W];
                vld_d[0] = beat_acc;
                for (int s = 1; s < j; s++) begin
                    dly_d[s] = dly_q[s-1];
                    vld_d[s] = vld_q[s-1];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < j; s++) dly_q[s] <= '0;
                    vld_q <= '0;
                end else begin
                    dly_q <= dly_d;
                    vld_q <= vld_d;
                end
            end
            assign b_skew[j]     = dly_q[j-1];
            assign b_skew_vld[j] = vld_q[j-1];
        end
    end

    // PE grid. Column 0 takes A from the skew lines and row 0 takes B from
    // the skew lines. Every other PE takes its operands from a neighbour.
    // A beat accepted at cycle t therefore meets in PE(i,j) at cycle t+1+i+j.
    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W-1:0] a_in_w, b_in_w;
            logic              a_vld_w, b_vld_w;
            if (j == 0) begin : g_a_edge
                assign a_in_w  = a_skew[i];
                assign a_vld_w = a_skew_vld[i];
            end else begin : g_a_chain
                assign a_in_w  = a_pass[i][j-1];
                assign a_vld_w = a_pass_vld[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in_w  = b_skew[j];
                assign b_vld_w = b_skew_vld[j];
            end else begin : g_b_chain
                assign b_in_w  = b_pass[i-1][j];
                assign b_vld_w = b_pass_vld[i-1][j];
            end
            gemm_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (start_acc),
                .a_in      (a_in_w),
                .a_vld_in  (a_vld_w),
                .b_in      (b_in_w),
                .b_vld_in  (b_vld_w),
                .a_out     (a_pass[i][j]),
                .a_vld_out (a_pass_vld[i][j]),
                .b_out     (b_pass[i][j]),
                .b_vld_out (b_pass_vld[i][j]),
                .acc_out   (acc[i][j])
            );
        end
    end

endmodule
